// File: rtl/vp_fb_queue.sv
// vp_fb_queue: in-order feedback buffer between out-of-order execution writeback
// and the value predictor's validation port; retires done entries oldest-first.
module vp_fb_queue #(
    parameter int P_DEPTH = 16,
    parameter int P_NUM_PRED = 2,
    localparam int P_TAG_WIDTH = $clog2(P_DEPTH)
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic                                    flush_i,
    input  logic [P_NUM_PRED-1:0]                   alloc_valid_i,
    input  logic [P_NUM_PRED-1:0][31:0]             alloc_pc_i,
    output logic                                    alloc_ready_o,
    output logic [P_NUM_PRED-1:0][P_TAG_WIDTH-1:0]  alloc_tag_o,
    input  logic [P_NUM_PRED-1:0]                   wb_valid_i,
    input  logic [P_NUM_PRED-1:0][P_TAG_WIDTH-1:0]  wb_tag_i,
    input  logic [P_NUM_PRED-1:0][31:0]             wb_result_i,
    output logic [P_NUM_PRED-1:0][31:0]             fb_pc_o,
    output logic [P_NUM_PRED-1:0][31:0]             fb_result_o,
    output logic [P_NUM_PRED-1:0]                   fb_valid_o,
    output logic [P_TAG_WIDTH:0]                    occupancy_o
);

    typedef logic [P_TAG_WIDTH:0]   ptr_t;
    typedef logic [P_TAG_WIDTH-1:0] tag_t;

    localparam ptr_t MAX_OCC = ptr_t'(P_DEPTH - P_NUM_PRED);

    logic [31:0]          pc_mem     [P_DEPTH];
    logic [31:0]          result_mem [P_DEPTH];
    logic [P_DEPTH-1:0]   alloc_bits;
    logic [P_DEPTH-1:0]   done_bits;
    ptr_t                 head;
    ptr_t                 tail;
    ptr_t                 occupancy;
    ptr_t                 alloc_cnt;
    ptr_t                 retire_cnt;
    logic                 retire_blocked;
    logic [P_NUM_PRED-1:0] retire_mask;
    tag_t [P_NUM_PRED-1:0] retire_slot;

    assign occupancy     = tail - head;
    assign occupancy_o   = occupancy;
    assign alloc_ready_o = (occupancy <= MAX_OCC);

    // Requesting lanes take consecutive slots from tail; idle lanes consume nothing.
    always_comb begin
        alloc_cnt   = '0;
        alloc_tag_o = '0;
        for (int l = 0; l < P_NUM_PRED; l++) begin
            alloc_tag_o[l] = tail[P_TAG_WIDTH-1:0] + alloc_cnt[P_TAG_WIDTH-1:0];
            if (alloc_valid_i[l]) begin
                alloc_cnt = alloc_cnt + ptr_t'(1);
            end
        end
    end

    // The first not-done entry from head blocks every younger entry.
    always_comb begin
        retire_blocked = 1'b0;
        retire_cnt     = '0;
        retire_mask    = '0;
        retire_slot    = '0;
        for (int j = 0; j < P_NUM_PRED; j++) begin
            retire_slot[j] = head[P_TAG_WIDTH-1:0] + tag_t'(j);
            if (!retire_blocked && alloc_bits[retire_slot[j]] && done_bits[retire_slot[j]]) begin
                retire_mask[j] = 1'b1;
                retire_cnt     = retire_cnt + ptr_t'(1);
            end else begin
                retire_blocked = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head        <= '0;
            tail        <= '0;
            alloc_bits  <= '0;
            done_bits   <= '0;
            fb_valid_o  <= '0;
            fb_pc_o     <= '0;
            fb_result_o <= '0;
        end else if (flush_i) begin
            head       <= '0;
            tail       <= '0;
            alloc_bits <= '0;
            done_bits  <= '0;
            fb_valid_o <= '0;
        end else begin
            for (int k = 0; k < P_NUM_PRED; k++) begin
                if (wb_valid_i[k] && alloc_bits[wb_tag_i[k]]) begin
                    done_bits[wb_tag_i[k]] <= 1'b1;
                end
            end
            // NOTE: with several non-blocking writes to one bit, the last in program
            // order wins, so the retire clear below overrides a same-cycle writeback.
            for (int j = 0; j < P_NUM_PRED; j++) begin
                if (retire_mask[j]) begin
                    alloc_bits[retire_slot[j]] <= 1'b0;
                    done_bits[retire_slot[j]]  <= 1'b0;
                    fb_pc_o[j]                 <= pc_mem[retire_slot[j]];
                    fb_result_o[j]             <= result_mem[retire_slot[j]];
                end
            end
            fb_valid_o <= retire_mask;
            head       <= head + retire_cnt;
            if (alloc_ready_o) begin
                for (int l = 0; l < P_NUM_PRED; l++) begin
                    if (alloc_valid_i[l]) begin
                        alloc_bits[alloc_tag_o[l]] <= 1'b1;
                        done_bits[alloc_tag_o[l]]  <= 1'b0;
                    end
                end
                tail <= tail + alloc_cnt;
            end
        end
    end

    // NOTE: payload arrays carry no reset; the alloc/done bits alone say which slots hold data.
    always_ff @(posedge clk_i) begin
        if (!flush_i) begin
            for (int k = 0; k < P_NUM_PRED; k++) begin
                if (wb_valid_i[k] && alloc_bits[wb_tag_i[k]]) begin
                    result_mem[wb_tag_i[k]] <= wb_result_i[k];
                end
            end
            if (alloc_ready_o) begin
                for (int l = 0; l < P_NUM_PRED; l++) begin
                    if (alloc_valid_i[l]) begin
                        pc_mem[alloc_tag_o[l]] <= alloc_pc_i[l];
                    end
                end
            end
        end
    end

endmodule
